// File: rtl/txt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : txt_pkg
// Purpose  : Opcodes, engine state encoding and blank-cell helper for the
//            text-mode command engine.
// Revision : 1.0
// ============================================================================
package txt_pkg;

    localparam logic [7:0] OP_RST  = 8'hC0;
    localparam logic [7:0] OP_PUT  = 8'hC1;
    localparam logic [7:0] OP_BS   = 8'hC2;
    localparam logic [7:0] OP_SETY = 8'hC3;
    localparam logic [7:0] OP_SETX = 8'hC4;
    localparam logic [7:0] OP_CLR  = 8'hC5;
    localparam logic [7:0] OP_NL   = 8'hC6;
    localparam logic [7:0] OP_ATTR = 8'hC7;

    typedef enum logic [2:0] {
        ST_GET_OP     = 3'd0,
        ST_GET_PARAM  = 3'd1,
        ST_EXEC       = 3'd2,
        ST_CLEAR      = 3'd3,
        ST_SCROLL_RD  = 3'd4,
        ST_SCROLL_WR  = 3'd5,
        ST_SCROLL_CLR = 3'd6
    } state_t;

    // Blank cell is the current attribute above a null character; caller truncates.
    function automatic logic [31:0] blank_cell(input logic [15:0] attr, input int char_w);
        return {16'h0000, attr} << char_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/text_ram.sv
`default_nettype none
// ============================================================================
// Module   : text_ram
// Purpose  : Character+attribute buffer. Port A engine read/write, port B
//            display read-only; both synchronous, read-first.
// Revision : 1.0
// ============================================================================
module text_ram
    import txt_pkg::*;
#(
    parameter int CELLS  = 1000,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic              i_a_we,
    input  logic [DATA_W-1:0] i_a_wdata,
    output logic [DATA_W-1:0] o_a_rdata,
    input  logic [ADDR_W-1:0] i_b_addr,
    output logic [DATA_W-1:0] o_b_rdata
);

    logic [DATA_W-1:0] r_mem [0:CELLS-1];
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;

    always_ff @(posedge clk) begin
        if (i_a_we) begin
            r_mem[i_a_addr] <= i_a_wdata;
        end
        r_a_rdata <= r_mem[i_a_addr];
    end

    // Scan-out addresses beyond the screen read as zero rather than aliasing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_b_rdata <= '0;
        end else if (i_b_addr < ADDR_W'(CELLS)) begin
            r_b_rdata <= r_mem[i_b_addr];
        end else begin
            r_b_rdata <= '0;
        end
    end

    assign o_a_rdata = r_a_rdata;
    assign o_b_rdata = r_b_rdata;

endmodule
`default_nettype wire

// File: rtl/txt_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module   : txt_cmd_engine
// Purpose  : Two-word command processor driving a cursor and a text buffer,
//            with clamped moves, hardware scroll and multi-cycle clear.
// Revision : 1.0
// ============================================================================
module txt_cmd_engine
    import txt_pkg::*;
#(
    parameter int              COLS         = 40,
    parameter int              ROWS         = 25,
    parameter int              CHAR_W       = 8,
    parameter int              ATTR_W       = 4,
    parameter int              ADDR_W       = 10,
    parameter logic [ATTR_W-1:0] ATTR_DEFAULT = 4'hF,
    parameter bit              SCROLL_EN    = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [15:0]                cpu_data,
    input  logic                       cpu_valid,
    output logic                       cpu_ready,
    output logic                       busy,
    output logic [$clog2(COLS)-1:0]    cur_x,
    output logic [$clog2(ROWS)-1:0]    cur_y,
    input  logic [ADDR_W-1:0]          disp_addr,
    output logic [CHAR_W+ATTR_W-1:0]   disp_data
);

    localparam int                c_X_W    = $clog2(COLS);
    localparam int                c_Y_W    = $clog2(ROWS);
    localparam int                c_DATA_W = CHAR_W + ATTR_W;
    localparam int                c_CELLS  = COLS * ROWS;
    localparam logic [ADDR_W-1:0] c_COLS_A = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] c_LAST   = ADDR_W'(c_CELLS - 1);
    localparam logic [ADDR_W-1:0] c_SCR_END = ADDR_W'((ROWS - 1) * COLS - 1);
    localparam logic [c_X_W-1:0]  c_X_MAX  = c_X_W'(COLS - 1);
    localparam logic [c_Y_W-1:0]  c_Y_MAX  = c_Y_W'(ROWS - 1);

    state_t              r_state, w_state_nx;
    logic [7:0]          r_op;
    logic [15:0]         r_param;
    logic [c_X_W-1:0]    r_x, w_x_nx, w_bs_x;
    logic [c_Y_W-1:0]    r_y, w_y_nx, w_bs_y;
    logic [ATTR_W-1:0]   r_attr, w_attr_nx;
    logic [ADDR_W-1:0]   r_sptr;
    logic [ADDR_W-1:0]   w_ptr;
    logic [ADDR_W-1:0]   w_a_addr;
    logic                w_a_we;
    logic [c_DATA_W-1:0] w_a_wdata, w_a_rdata, w_blank;
    logic                w_xfer, w_adv;

    assign w_ptr   = ADDR_W'(r_y) * c_COLS_A + ADDR_W'(r_x);
    assign w_blank = c_DATA_W'(blank_cell(16'(r_attr), CHAR_W));
    assign w_xfer  = cpu_valid & cpu_ready;

    always_comb begin
        w_state_nx = r_state;
        w_x_nx     = r_x;
        w_y_nx     = r_y;
        w_attr_nx  = r_attr;
        w_a_addr   = w_ptr;
        w_a_we     = 1'b0;
        w_a_wdata  = w_blank;
        w_adv      = 1'b0;
        w_bs_x     = r_x;
        w_bs_y     = r_y;
        case (r_state)
            ST_GET_OP:    if (w_xfer) w_state_nx = ST_GET_PARAM;
            ST_GET_PARAM: if (w_xfer) w_state_nx = ST_EXEC;
            ST_EXEC: begin
                w_state_nx = ST_GET_OP;
                case (r_op)
                    OP_RST: begin
                        w_x_nx    = '0;
                        w_y_nx    = '0;
                        w_attr_nx = ATTR_DEFAULT;
                    end
                    OP_PUT: begin
                        w_a_we    = 1'b1;
                        w_a_wdata = {r_attr, r_param[CHAR_W-1:0]};
                        if (r_x == c_X_MAX) w_adv = 1'b1;
                        else                w_x_nx = r_x + 1'b1;
                    end
                    OP_BS: begin
                        if (r_x != '0) begin
                            w_bs_x = r_x - 1'b1;
                        end else if (r_y != '0) begin
                            w_bs_x = c_X_MAX;
                            w_bs_y = r_y - 1'b1;
                        end
                        w_x_nx   = w_bs_x;
                        w_y_nx   = w_bs_y;
                        w_a_addr = ADDR_W'(w_bs_y) * c_COLS_A + ADDR_W'(w_bs_x);
                        w_a_we   = 1'b1;
                    end
                    OP_SETY: w_y_nx = (r_param > 16'(ROWS - 1)) ? c_Y_MAX : c_Y_W'(r_param);
                    OP_SETX: w_x_nx = (r_param > 16'(COLS - 1)) ? c_X_MAX : c_X_W'(r_param);
                    OP_CLR: begin
                        w_x_nx     = '0;
                        w_y_nx     = '0;
                        w_state_nx = ST_CLEAR;
                    end
                    OP_NL:   w_adv     = 1'b1;
                    OP_ATTR: w_attr_nx = r_param[ATTR_W-1:0];
                    default: ;
                endcase
                // Line advance: bottom row either scrolls in place or wraps to the top.
                if (w_adv) begin
                    w_x_nx = '0;
                    if (r_y != c_Y_MAX)  w_y_nx = r_y + 1'b1;
                    else if (SCROLL_EN)  w_state_nx = ST_SCROLL_RD;
                    else                 w_y_nx = '0;
                end
            end
            ST_CLEAR: begin
                w_a_addr = r_sptr;
                w_a_we   = 1'b1;
                if (r_sptr == c_LAST) w_state_nx = ST_GET_OP;
            end
            ST_SCROLL_RD: begin
                w_a_addr   = r_sptr + c_COLS_A;
                w_state_nx = ST_SCROLL_WR;
            end
            ST_SCROLL_WR: begin
                w_a_addr   = r_sptr;
                w_a_we     = 1'b1;
                w_a_wdata  = w_a_rdata;
                w_state_nx = (r_sptr == c_SCR_END) ? ST_SCROLL_CLR : ST_SCROLL_RD;
            end
            ST_SCROLL_CLR: begin
                w_a_addr = r_sptr;
                w_a_we   = 1'b1;
                if (r_sptr == c_LAST) w_state_nx = ST_GET_OP;
            end
            default: w_state_nx = ST_GET_OP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_GET_OP;
            r_op    <= '0;
            r_param <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_attr  <= ATTR_DEFAULT;
            r_sptr  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_x     <= w_x_nx;
            r_y     <= w_y_nx;
            r_attr  <= w_attr_nx;
            if (r_state == ST_GET_OP && w_xfer)    r_op    <= cpu_data[7:0];
            if (r_state == ST_GET_PARAM && w_xfer) r_param <= cpu_data;
            case (r_state)
                ST_EXEC:                               r_sptr <= '0;
                ST_CLEAR, ST_SCROLL_WR, ST_SCROLL_CLR: r_sptr <= r_sptr + 1'b1;
                default: ;
            endcase
        end
    end

    assign cpu_ready = ~reset & ((r_state == ST_GET_OP) | (r_state == ST_GET_PARAM));
    assign busy      = ~reset & ~((r_state == ST_GET_OP) | (r_state == ST_GET_PARAM));
    assign cur_x     = r_x;
    assign cur_y     = r_y;

    // Writes are suppressed in a reset cycle so an aborted command stops cleanly.
    text_ram #(
        .CELLS  (c_CELLS),
        .ADDR_W (ADDR_W),
        .DATA_W (c_DATA_W)
    ) u_ram (
        .clk       (clk),
        .rst       (reset),
        .i_a_addr  (w_a_addr),
        .i_a_we    (w_a_we & ~reset),
        .i_a_wdata (w_a_wdata),
        .o_a_rdata (w_a_rdata),
        .i_b_addr  (disp_addr),
        .o_b_rdata (disp_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_txt_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_txt_cmd_engine
// Purpose  : Scoreboard bench for txt_cmd_engine against a screen-level model.
// Revision : 1.0
// ============================================================================
module tb_txt_cmd_engine;

    localparam int COLS  = 40;
    localparam int ROWS  = 25;
    localparam int CELLS = COLS * ROWS;
    localparam int SCROLL_CYC = 2 * (ROWS - 1) * COLS + COLS;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_data;
    logic        cpu_valid, cpu_valid_ns;
    logic        cpu_ready, cpu_ready_ns, busy, busy_ns;
    logic [5:0]  cur_x, cur_x_ns;
    logic [4:0]  cur_y, cur_y_ns;
    logic [9:0]  disp_addr, disp_addr_ns;
    logic [11:0] disp_data, disp_data_ns;

    always #5 clk = ~clk;

    txt_cmd_engine dut (
        .clk(clk), .reset(reset), .cpu_data(cpu_data), .cpu_valid(cpu_valid),
        .cpu_ready(cpu_ready), .busy(busy), .cur_x(cur_x), .cur_y(cur_y),
        .disp_addr(disp_addr), .disp_data(disp_data)
    );

    txt_cmd_engine #(.SCROLL_EN(1'b0)) dut_ns (
        .clk(clk), .reset(reset), .cpu_data(cpu_data), .cpu_valid(cpu_valid_ns),
        .cpu_ready(cpu_ready_ns), .busy(busy_ns), .cur_x(cur_x_ns), .cur_y(cur_y_ns),
        .disp_addr(disp_addr_ns), .disp_data(disp_data_ns)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- screen model ----------------
    logic [11:0] m_mem [0:CELLS-1];
    int          mx, my;
    logic [3:0]  mattr;

    function automatic logic [11:0] blank();
        return {mattr, 8'h00};
    endfunction

    task automatic model_line_adv(inout int blen);
        mx = 0;
        if (my < ROWS - 1) my++;
        else begin
            for (int i = 0; i < (ROWS - 1) * COLS; i++) m_mem[i] = m_mem[i + COLS];
            for (int i = (ROWS - 1) * COLS; i < CELLS; i++) m_mem[i] = blank();
            blen += SCROLL_CYC;
        end
    endtask

    task automatic model_cmd(input logic [7:0] op, input logic [15:0] p, output int blen);
        blen = 1;
        case (op)
            8'hC0: begin mx = 0; my = 0; mattr = 4'hF; end
            8'hC1: begin
                m_mem[my * COLS + mx] = {mattr, p[7:0]};
                if (mx == COLS - 1) model_line_adv(blen);
                else mx++;
            end
            8'hC2: begin
                if (mx > 0) mx--;
                else if (my > 0) begin mx = COLS - 1; my--; end
                m_mem[my * COLS + mx] = blank();
            end
            8'hC3: my = (int'(p) > ROWS - 1) ? ROWS - 1 : int'(p);
            8'hC4: mx = (int'(p) > COLS - 1) ? COLS - 1 : int'(p);
            8'hC5: begin
                for (int i = 0; i < CELLS; i++) m_mem[i] = blank();
                mx = 0; my = 0; blen += CELLS;
            end
            8'hC6: model_line_adv(blen);
            8'hC7: mattr = p[3:0];
            default: ;
        endcase
    endtask

    // ---------------- scoreboard ----------------
    typedef struct { int x; int y; int blen; } cmd_exp_t;
    cmd_exp_t    cq[$];
    logic [11:0] dq[$];
    logic        disp_req = 1'b0;
    logic        req_d = 1'b0;
    int          run = 0;
    cmd_exp_t    m_c;
    logic [11:0] m_e;

    always @(posedge clk) req_d <= disp_req;

    always @(negedge clk) begin
        if (req_d) begin
            if (dq.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL disp_unexpected: got 0x%0h expected none", disp_data);
            end else begin
                m_e = dq.pop_front();
                check("disp_data", 32'(disp_data), 32'(m_e));
            end
        end
        if (reset) run = 0;
        else if (busy) run++;
        else if (run > 0) begin
            if (cq.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL cmd_unexpected: got busy run %0d expected none", run);
            end else begin
                m_c = cq.pop_front();
                check("cur_x", 32'(cur_x), 32'(m_c.x));
                check("cur_y", 32'(cur_y), 32'(m_c.y));
                check("busy_len", 32'(run), 32'(m_c.blen));
            end
            run = 0;
        end
    end

    // ---------------- stimulus ----------------
    int tgt = 0;

    task automatic send_word(input logic [15:0] w);
        int n = 0;
        cpu_data = w;
        if (tgt == 0) cpu_valid = 1'b1; else cpu_valid_ns = 1'b1;
        while (((tgt == 0) ? cpu_ready : cpu_ready_ns) !== 1'b1) begin
            if (n >= 5000) begin
                n_checks++; n_errors++;
                $display("FAIL handshake_timeout: got ready=0 expected ready=1");
                break;
            end
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        cpu_valid = 1'b0; cpu_valid_ns = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] op, input logic [15:0] p, input bit push = 1'b1);
        int bl;
        send_word({8'($urandom), op});
        if (tgt == 0 && push) begin
            model_cmd(op, p, bl);
            cq.push_back('{mx, my, bl});
        end
        send_word(p);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (((tgt == 0) ? cpu_ready : cpu_ready_ns) !== 1'b1) begin
            if (n >= 5000) begin
                n_checks++; n_errors++;
                $display("FAIL idle_timeout: got ready=0 expected ready=1");
                break;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic chk_disp(input int a);
        disp_addr = 10'(a);
        disp_req  = 1'b1;
        dq.push_back(m_mem[a]);
        @(negedge clk);
        disp_req = 1'b0;
    endtask

    task automatic chk_ns(input int a, input logic [11:0] exp);
        disp_addr_ns = 10'(a);
        @(negedge clk);
        check("ns_disp", 32'(disp_data_ns), 32'(exp));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] op;
        reset = 1'b1; cpu_data = '0; cpu_valid = 1'b0; cpu_valid_ns = 1'b0;
        disp_addr = '0; disp_addr_ns = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(cpu_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_x", 32'(cur_x), 0);
        check("rst_y", 32'(cur_y), 0);
        check("rst_disp", 32'(disp_data), 0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(cpu_ready), 1);
        mx = 0; my = 0; mattr = 4'hF;

        cmd(8'hC5, 16'h0);
        cmd(8'hC1, 16'h41);
        cmd(8'hC1, 16'h42);
        wait_idle();
        chk_disp(0); chk_disp(1);
        check("put_cur_x", 32'(cur_x), 2);

        cmd(8'hC4, 16'd39);
        cmd(8'hC7, 16'h3);
        cmd(8'hC1, 16'h5A);
        wait_idle();
        chk_disp(39);
        cmd(8'hC2, 16'h0);
        wait_idle();
        chk_disp(39);

        cmd(8'hC4, 16'd100);
        cmd(8'hC3, 16'd200);
        cmd(8'hC4, 16'd0);
        cmd(8'hC3, 16'd0);
        cmd(8'hC2, 16'h0);
        wait_idle();
        chk_disp(0);

        // Fill screen with row numbers; the final put char triggers a scroll.
        cmd(8'hC0, 16'h0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                cmd(8'hC1, 16'(r));
        wait_idle();
        for (int i = 0; i < CELLS; i++) chk_disp(i);
        cmd(8'hC6, 16'h0);
        wait_idle();
        for (int i = 0; i < CELLS; i += 7) chk_disp(i);

        for (int k = 0; k < 200; k++) begin
            n = $urandom_range(0, 99);
            if      (n < 35) cmd(8'hC1, 16'($urandom));
            else if (n < 45) cmd(8'hC2, 16'($urandom));
            else if (n < 55) cmd(8'hC3, 16'($urandom_range(0, 31)));
            else if (n < 65) cmd(8'hC4, 16'($urandom_range(0, 63)));
            else if (n < 70) cmd(8'hC6, 16'($urandom));
            else if (n < 78) cmd(8'hC7, 16'($urandom));
            else if (n < 80) cmd(8'hC0, 16'($urandom));
            else if (n < 81) cmd(8'hC5, 16'($urandom));
            else if (n < 90) begin
                op = 8'($urandom);
                if (op[7:3] == 5'b11000) op = op ^ 8'h10;
                cmd(op, 16'($urandom));
            end else cmd(8'hC1, 16'($urandom));
        end
        wait_idle();
        for (int i = 0; i < 100; i++) chk_disp($urandom_range(0, CELLS - 1));

        // Reset during clear: exactly cells 0..99 blanked before abort.
        cmd(8'hC7, 16'h9);
        mattr = 4'h9;
        cq.delete(cq.size() - 1);
        cq.push_back('{mx, my, 1});
        for (int i = 0; i < 5; i++) cmd(8'hC1, 16'(8'h61 + i));
        cmd(8'hC5, 16'h0, 1'b0);
        repeat (101) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 100; i++) m_mem[i] = {mattr, 8'h00};
        mx = 0; my = 0; mattr = 4'hF;
        @(negedge clk);
        check("abort_busy_in_rst", 32'(busy), 0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(cpu_ready), 1);
        check("abort_busy", 32'(busy), 0);
        check("abort_x", 32'(cur_x), 0);
        check("abort_y", 32'(cur_y), 0);
        for (int i = 0; i < 200; i++) chk_disp(i);

        // Wrap-around variant without scroll.
        tgt = 1;
        cmd(8'hC5, 16'h0);
        cmd(8'hC4, 16'd0);
        cmd(8'hC3, 16'd24);
        cmd(8'hC1, 16'h41);
        wait_idle();
        check("ns_x1", 32'(cur_x_ns), 1);
        check("ns_y1", 32'(cur_y_ns), 24);
        cmd(8'hC4, 16'd39);
        cmd(8'hC1, 16'h42);
        wait_idle();
        check("ns_wrap_x", 32'(cur_x_ns), 0);
        check("ns_wrap_y", 32'(cur_y_ns), 0);
        cmd(8'hC3, 16'd24);
        cmd(8'hC4, 16'd0);
        send_word(16'h00C6);
        send_word(16'h0000);
        n = 0;
        while (busy_ns === 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
        check("ns_nl_busy", 32'(n), 1);
        check("ns_nl_x", 32'(cur_x_ns), 0);
        check("ns_nl_y", 32'(cur_y_ns), 0);
        chk_ns(960, 12'hF41);
        chk_ns(999, 12'hF42);
        chk_ns(961, 12'hF00);
        chk_ns(0, 12'hF00);
        tgt = 0;

        repeat (5) @(negedge clk);
        check("cmd_queue_drained", 32'(cq.size()), 0);
        check("disp_queue_drained", 32'(dq.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
